// File: rtl/dice_game_ctrl.sv
// N-player dice game core: turn sequencing, tumble animation, saturating score accumulation,
// optional bonus re-roll on a top face, round counting and winner/tie resolution.
module dice_game_ctrl #(
    parameter int unsigned  PLAYERS     = 2,
    parameter int unsigned  FACES       = 6,
    parameter int unsigned  ROUNDS      = 5,
    parameter int unsigned  ROLL_CYCLES = 8,
    parameter int unsigned  SCORE_W     = 6,
    parameter bit           BONUS_EN    = 1'b1,
    localparam int unsigned FW          = $clog2(FACES + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tick,
    input  logic [PLAYERS-1:0]         roll_req,
    output logic [PLAYERS*FW-1:0]      face,
    output logic [PLAYERS*SCORE_W-1:0] score,
    output logic [1:0]                 turn,
    output logic [3:0]                 round_cnt,
    output logic                       busy,
    output logic [PLAYERS-1:0]         winner,
    output logic                       game_over,
    output logic                       final_pulse
);

    // Sum is wide enough for either operand plus a carry, so saturation never sees a wrap.
    localparam int unsigned     SumW     = ((SCORE_W > FW) ? SCORE_W : FW) + 1;
    localparam logic [SumW-1:0] ScoreMax = SumW'((64'd1 << SCORE_W) - 64'd1);

    typedef enum logic [1:0] {StWait, StRolling, StCommit, StDone} state_e;

    state_e             state_q, state_d;
    logic [FW-1:0]      face_free_q, face_free_d;
    logic [7:0]         tumble_q, tumble_d;
    logic [FW-1:0]      face_q  [PLAYERS];
    logic [FW-1:0]      face_d  [PLAYERS];
    logic [SCORE_W-1:0] score_q [PLAYERS];
    logic [SCORE_W-1:0] score_d [PLAYERS];
    logic [1:0]         turn_q, turn_d;
    logic [3:0]         round_q, round_d;
    logic               bonus_q, bonus_d;
    logic [PLAYERS-1:0] winner_q, winner_d;
    logic               game_over_q, game_over_d;
    logic               final_q, final_d;

    logic               req_hit;
    logic [FW-1:0]      cur_face;
    logic [SCORE_W-1:0] cur_score;
    logic [SumW-1:0]    sum;
    logic [SCORE_W-1:0] sat_score;
    logic [SCORE_W-1:0] best;
    logic               last_seat;

    always_comb begin
        req_hit   = 1'b0;
        cur_face  = '0;
        cur_score = '0;
        for (int p = 0; p < PLAYERS; p++) begin
            if (turn_q == 2'(p)) begin
                req_hit   = roll_req[p];
                cur_face  = face_q[p];
                cur_score = score_q[p];
            end
        end
    end

    assign sum         = SumW'(cur_score) + SumW'(cur_face);
    assign sat_score   = (sum > ScoreMax) ? SCORE_W'(ScoreMax) : SCORE_W'(sum);
    assign last_seat   = (turn_q == 2'(PLAYERS - 1));
    // Free-running so the captured face depends only on press timing.
    assign face_free_d = (face_free_q == FW'(FACES)) ? FW'(1) : face_free_q + FW'(1);

    always_comb begin
        state_d     = state_q;
        tumble_d    = tumble_q;
        face_d      = face_q;
        score_d     = score_q;
        turn_d      = turn_q;
        round_d     = round_q;
        bonus_d     = bonus_q;
        winner_d    = winner_q;
        game_over_d = game_over_q;
        final_d     = 1'b0;
        best        = '0;

        case (state_q)
            StWait: begin
                if (req_hit) begin
                    tumble_d = 8'(ROLL_CYCLES);
                    state_d  = StRolling;
                end
            end
            StRolling: begin
                if (tick) begin
                    for (int p = 0; p < PLAYERS; p++) begin
                        if (turn_q == 2'(p)) face_d[p] = face_free_q;
                    end
                    tumble_d = tumble_q - 8'd1;
                    if (tumble_q == 8'd1) state_d = StCommit;
                end
            end
            StCommit: begin
                for (int p = 0; p < PLAYERS; p++) begin
                    if (turn_q == 2'(p)) score_d[p] = sat_score;
                end
                if (BONUS_EN && (cur_face == FW'(FACES)) && !bonus_q) begin
                    bonus_d = 1'b1;
                    state_d = StWait;
                end else begin
                    bonus_d = 1'b0;
                    if (last_seat) begin
                        turn_d  = '0;
                        round_d = round_q + 4'd1;
                    end else begin
                        turn_d = turn_q + 2'd1;
                    end
                    if (round_d == 4'(ROUNDS)) begin
                        state_d     = StDone;
                        game_over_d = 1'b1;
                        final_d     = 1'b1;
                        // Resolve against the freshly committed scores so winner is valid
                        // in the first DONE cycle.
                        for (int p = 0; p < PLAYERS; p++) begin
                            if (score_d[p] > best) best = score_d[p];
                        end
                        for (int p = 0; p < PLAYERS; p++) begin
                            winner_d[p] = (score_d[p] == best);
                        end
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StDone: begin
                if (roll_req[0]) begin
                    state_d = StWait;
                    for (int p = 0; p < PLAYERS; p++) begin
                        face_d[p]  = '0;
                        score_d[p] = '0;
                    end
                    turn_d      = '0;
                    round_d     = '0;
                    bonus_d     = 1'b0;
                    winner_d    = '0;
                    game_over_d = 1'b0;
                end
            end
            default: state_d = StWait;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StWait;
            face_free_q <= FW'(1);
            tumble_q    <= '0;
            turn_q      <= '0;
            round_q     <= '0;
            bonus_q     <= 1'b0;
            winner_q    <= '0;
            game_over_q <= 1'b0;
            final_q     <= 1'b0;
            for (int p = 0; p < PLAYERS; p++) begin
                face_q[p]  <= '0;
                score_q[p] <= '0;
            end
        end else begin
            state_q     <= state_d;
            face_free_q <= face_free_d;
            tumble_q    <= tumble_d;
            turn_q      <= turn_d;
            round_q     <= round_d;
            bonus_q     <= bonus_d;
            winner_q    <= winner_d;
            game_over_q <= game_over_d;
            final_q     <= final_d;
            for (int p = 0; p < PLAYERS; p++) begin
                face_q[p]  <= face_d[p];
                score_q[p] <= score_d[p];
            end
        end
    end

    always_comb begin
        face  = '0;
        score = '0;
        for (int p = 0; p < PLAYERS; p++) begin
            face[p*FW +: FW]            = face_q[p];
            score[p*SCORE_W +: SCORE_W] = score_q[p];
        end
    end

    assign turn        = turn_q;
    assign round_cnt   = round_q;
    assign busy        = (state_q == StRolling) || (state_q == StCommit);
    assign winner      = winner_q;
    assign game_over   = game_over_q;
    assign final_pulse = final_q;

endmodule

// File: tb/tb_dice_game_ctrl.sv
// Bench for dice_game_ctrl: a directed game from a vector table, randomized games against a
// roll-level score model, restart in DONE and asynchronous reset during a tumble.
module tb_dice_game_ctrl;

    localparam int unsigned PLAYERS     = 3;
    localparam int unsigned FACES       = 6;
    localparam int unsigned ROUNDS      = 2;
    localparam int unsigned ROLL_CYCLES = 4;
    localparam int unsigned SCORE_W     = 3;
    localparam bit          BONUS_EN    = 1'b1;
    localparam int unsigned FW          = $clog2(FACES + 1);
    localparam int          ScoreMax    = (1 << SCORE_W) - 1;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       tick;
    logic [PLAYERS-1:0]         roll_req;
    logic [PLAYERS*FW-1:0]      face;
    logic [PLAYERS*SCORE_W-1:0] score;
    logic [1:0]                 turn;
    logic [3:0]                 round_cnt;
    logic                       busy;
    logic [PLAYERS-1:0]         winner;
    logic                       game_over;
    logic                       final_pulse;

    dice_game_ctrl #(
        .PLAYERS    (PLAYERS),
        .FACES      (FACES),
        .ROUNDS     (ROUNDS),
        .ROLL_CYCLES(ROLL_CYCLES),
        .SCORE_W    (SCORE_W),
        .BONUS_EN   (BONUS_EN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .roll_req   (roll_req),
        .face       (face),
        .score      (score),
        .turn       (turn),
        .round_cnt  (round_cnt),
        .busy       (busy),
        .winner     (winner),
        .game_over  (game_over),
        .final_pulse(final_pulse)
    );

    always #5 clk = ~clk;

    // Face the die would show if sampled at the coming edge: 1..FACES cycling every clk.
    int ff_m;
    always @(posedge clk or negedge rst) begin
        if (!rst) ff_m <= 1;
        else      ff_m <= (ff_m % FACES) + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int sc [PLAYERS];
    int fm [PLAYERS];
    int turn_m, rnd_m;
    bit bonus_m, done_m;

    typedef struct {
        int                 player;
        int                 face_v;
        int                 exp_score;
        int                 exp_turn;
        int                 exp_round;
        bit                 exp_done;
        logic [PLAYERS-1:0] exp_win;
    } vec_t;
    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PLAYERS*FW-1:0] face_vec();
        logic [PLAYERS*FW-1:0] v = '0;
        for (int p = 0; p < PLAYERS; p++) v[p*FW +: FW] = FW'(fm[p]);
        return v;
    endfunction

    function automatic logic [PLAYERS*SCORE_W-1:0] score_vec();
        logic [PLAYERS*SCORE_W-1:0] v = '0;
        for (int p = 0; p < PLAYERS; p++) v[p*SCORE_W +: SCORE_W] = SCORE_W'(sc[p]);
        return v;
    endfunction

    function automatic logic [PLAYERS-1:0] win_vec();
        logic [PLAYERS-1:0] w = '0;
        int best = 0;
        for (int p = 0; p < PLAYERS; p++) if (sc[p] > best) best = sc[p];
        for (int p = 0; p < PLAYERS; p++) w[p] = (sc[p] == best);
        return w;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < PLAYERS; p++) begin
            sc[p] = 0;
            fm[p] = 0;
        end
        turn_m  = 0;
        rnd_m   = 0;
        bonus_m = 1'b0;
        done_m  = 1'b0;
    endtask

    task automatic model_commit(input int f);
        fm[turn_m] = f;
        sc[turn_m] = (sc[turn_m] + f > ScoreMax) ? ScoreMax : sc[turn_m] + f;
        if (BONUS_EN && f == FACES && !bonus_m) begin
            bonus_m = 1'b1;
        end else begin
            bonus_m = 1'b0;
            turn_m  = (turn_m + 1) % PLAYERS;
            if (turn_m == 0) rnd_m++;
            done_m = (rnd_m == ROUNDS);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_face"}, face, 0);
        chk({tag, "_score"}, score, 0);
        chk({tag, "_turn"}, turn, 0);
        chk({tag, "_round"}, round_cnt, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_winner"}, winner, 0);
        chk({tag, "_game_over"}, game_over, 0);
        chk({tag, "_final"}, final_pulse, 0);
    endtask

    task automatic idle(input logic tk, input logic [PLAYERS-1:0] own);
        roll_req = PLAYERS'($urandom) & ~own;
        tick     = tk;
        step();
        chk("idle_busy", busy, 0);
    endtask

    // One complete turn of the current player; returns one cycle after the commit edge.
    task automatic do_roll(input bit directed, input int target);
        int                 want, guard, left, cap;
        logic [PLAYERS-1:0] own;
        own = PLAYERS'(1) << turn_m;
        cap = 0;
        if (directed) begin
            want  = ((target - 1 - int'(ROLL_CYCLES)) % int'(FACES) + int'(FACES))
                    % int'(FACES) + 1;
            guard = 0;
            while (ff_m != want && guard < 2 * FACES) begin
                idle(1'b1, own);
                guard++;
            end
        end else begin
            repeat ($urandom_range(0, 3)) idle(1'($urandom_range(0, 1)), own);
        end
        roll_req = own | PLAYERS'($urandom);
        tick     = directed ? 1'b1 : 1'($urandom_range(0, 1));
        step();
        chk("press_busy", busy, 1);
        left  = ROLL_CYCLES;
        guard = 0;
        while (left > 0 && guard < 1000) begin
            roll_req = PLAYERS'($urandom);
            tick     = directed ? 1'b1 : 1'($urandom_range(0, 1));
            if (tick) begin
                cap = ff_m;
                left--;
            end
            step();
            guard++;
            chk("tumble_busy", busy, 1);
            if (tick) chk("tumble_face", face[turn_m*FW +: FW], cap);
        end
        if (left > 0) chk("tumble_bound", left, 0);
        chk("commit_score_hold", score, score_vec());
        roll_req = '1;
        tick     = 1'($urandom_range(0, 1));
        step();
        model_commit(cap);
        chk("face_vec", face, face_vec());
        chk("score_vec", score, score_vec());
        chk("turn", turn, turn_m);
        chk("round_cnt", round_cnt, rnd_m);
        chk("post_commit_busy", busy, 0);
        chk("game_over", game_over, done_m);
        chk("final_pulse", final_pulse, done_m);
        if (done_m) chk("winner", winner, win_vec());
        if (!done_m) begin
            roll_req = '0;
            step();
            chk("commit_req_ignored", busy, 0);
        end else begin
            roll_req = PLAYERS'($urandom) & ~PLAYERS'(1);
            step();
            chk("final_pulse_once", final_pulse, 0);
            chk("done_hold", game_over, 1);
            chk("done_winner_hold", winner, win_vec());
            chk("done_busy", busy, 0);
        end
        roll_req = '0;
    endtask

    task automatic restart();
        roll_req = PLAYERS'(1) | PLAYERS'($urandom);
        step();
        roll_req = '0;
        model_reset();
        check_zero("restart");
    endtask

    initial begin
        int guard;
        logic [PLAYERS-1:0] own;

        vecs[0] = '{0, 3, 3, 1, 0, 1'b0, 3'b000};
        vecs[1] = '{1, 6, 6, 1, 0, 1'b0, 3'b000};
        vecs[2] = '{1, 6, 7, 2, 0, 1'b0, 3'b000};
        vecs[3] = '{2, 5, 5, 0, 1, 1'b0, 3'b000};
        vecs[4] = '{0, 4, 7, 1, 1, 1'b0, 3'b000};
        vecs[5] = '{1, 6, 7, 1, 1, 1'b0, 3'b000};
        vecs[6] = '{1, 1, 7, 2, 1, 1'b0, 3'b000};
        vecs[7] = '{2, 1, 6, 0, 2, 1'b1, 3'b011};

        rst      = 1'b1;
        tick     = 1'b0;
        roll_req = '0;
        model_reset();
        #2 rst = 1'b0;
        #1 check_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        check_zero("release");

        for (int i = 0; i < 8; i++) begin
            chk("vec_turn_before", turn, vecs[i].player);
            do_roll(1'b1, vecs[i].face_v);
            chk("vec_face", face[vecs[i].player*FW +: FW], vecs[i].face_v);
            chk("vec_score", score[vecs[i].player*SCORE_W +: SCORE_W], vecs[i].exp_score);
            chk("vec_turn", turn, vecs[i].exp_turn);
            chk("vec_round", round_cnt, vecs[i].exp_round);
            chk("vec_done", game_over, vecs[i].exp_done);
            if (vecs[i].exp_done) chk("vec_winner", winner, vecs[i].exp_win);
        end
        restart();

        for (int g = 0; g < 8; g++) begin
            guard = 0;
            while (!done_m && guard < 64) begin
                do_roll(1'b0, 0);
                guard++;
            end
            chk("game_done", game_over, 1);
            restart();
        end

        // Asynchronous reset in the middle of a tumble.
        do_roll(1'b0, 0);
        do_roll(1'b0, 0);
        own      = PLAYERS'(1) << turn_m;
        roll_req = own;
        tick     = 1'b0;
        step();
        roll_req = '0;
        tick     = 1'b1;
        step();
        step();
        chk("pre_reset_busy", busy, 1);
        #3 rst = 1'b0;
        #1 check_zero("async_reset");
        model_reset();
        tick = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        roll_req = PLAYERS'(6);
        tick     = 1'b1;
        step();
        chk("reset_other_ignored", busy, 0);
        roll_req = '0;
        step();
        chk("reset_turn0", turn, 0);
        do_roll(1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dice_game_ctrl.md
# dice_game_ctrl

Parametrised N-player dice game core: turn-based roll sequencing, tumble animation, score accumulation, bonus re-roll, round counting and winner/tie resolution. It generalises the two-player dice top-level to PLAYERS seats and a configurable die and game length. It sits between the per-button debouncers and prescaler on the input side, and the dot-matrix, segment, RGB and music blocks on the output side.

## Interface
- PLAYERS, 2: number of players, legal range 2..4.
- FACES, 6: die faces, legal range 2..9. FW = $clog2(FACES+1).
- ROUNDS, 5: rounds per game, legal range 1..15.
- ROLL_CYCLES, 8: tick count of the tumble animation, legal range 1..255.
- SCORE_W, 6: per-player score width.
- BONUS_EN, 1: 1 grants one extra roll per turn on a top face.
- clk in 1: system clock.
- rst in 1: reset, asynchronous, active-low.
- tick in 1: one-clk enable pulse from the prescaler.
- roll_req in PLAYERS: debounced one-clk press pulses, one per player.
- face out PLAYERS*FW: current die face per player. Player p is at [p*FW +: FW]. A value of 0 means blank.
- score out PLAYERS*SCORE_W: packed per-player scores.
- turn out 2: index of the player whose roll is accepted.
- round_cnt out 4: completed rounds.
- busy out 1: high in ROLLING and COMMIT.
- winner out PLAYERS: one-hot winner, or several bits set on a tie. Valid only while game_over is high.
- game_over out 1: high level in DONE.
- final_pulse out 1: one-clk pulse on entry to DONE.

## Operation
- States: WAIT, ROLLING, COMMIT, DONE.
- Reset values:
  - State WAIT.
  - face, score, turn, round_cnt, busy, winner, game_over and final_pulse are all 0.
  - face_free = 1, bonus_used = 0.
- face_free is a free-running counter that advances every clk with no dependence on tick: 1, 2, …, FACES, 1, …. Press timing supplies the randomness.
- WAIT:
  - Only roll_req[turn] is considered.
  - Other bits and bits ≥ PLAYERS are ignored.
  - On acceptance, load tumble counter = ROLL_CYCLES and go to ROLLING.
- ROLLING:
  - On each tick, face[turn] ← face_free and the tumble counter is decremented.
  - On the tick that takes the counter to 0, go to COMMIT. The face written on that tick is the final value.
  - All roll_req are ignored.
- COMMIT, which lasts exactly one clk:
  - score[turn] ← min(score[turn] + face[turn], 2^SCORE_W − 1). Saturating, with no wrap.
  - If BONUS_EN is set, face[turn] == FACES and bonus_used = 0: set bonus_used and go to WAIT with turn unchanged.
  - Otherwise:
    - Clear bonus_used.
    - If turn == PLAYERS−1: turn ← 0 and round_cnt ← round_cnt+1.
    - Otherwise: turn ← turn+1.
    - If the new round_cnt == ROUNDS, go to DONE; otherwise go to WAIT.
- DONE:
  - winner[p] = 1 for every p whose score equals the maximum score.
  - game_over = 1.
  - final_pulse is high only on the first clk of DONE.
  - roll_req[0] restarts the game:
    - scores, faces and round_cnt are cleared, turn = 0, bonus_used = 0 and winner = 0.
    - Next state is WAIT.
  - Other requests are ignored.
- Faces of non-active players hold their last value across turns.

## Timing
- Press to busy: roll_req[turn] high in cycle n puts busy high in cycle n+1.
- Tumble:
  - The tumble lasts exactly ROLL_CYCLES tick pulses counted after entry.
  - A tick coinciding with the acceptance cycle does not count.
- Final tick to score: final tick in cycle m updates score in cycle m+2 (COMMIT in m+1, registered result in m+2).
- Turn and round_cnt update on the same edge as score.
- COMMIT to DONE: final_pulse is asserted on the first clk after the last COMMIT.
- game_over and winner are registered and valid from the same cycle as final_pulse.
- Restart: a restart request in DONE at cycle k gives game_over = 0 and all scores 0 at cycle k+1.
- Reset mid-operation: asserting rst forces every output to its reset value immediately, from any state. Nothing is held across reset.
- A roll_req pulse on the COMMIT→WAIT transition cycle is not accepted. A request must arrive while in WAIT.

## Test plan
- Single roll, with PLAYERS=2, FACES=6, ROLL_CYCLES=4 and tick tied high:
  - Press player 0 so that the 4th ROLLING tick samples face_free=3.
  - Required: face0=3, score0=3 two clks later, turn=1, busy low.
- Wrong-player and busy rejection:
  - Pulse roll_req[1] while turn=0, then roll_req[0] twice during ROLLING.
  - Required: exactly one roll, score1 unchanged, turn=1 after commit.
- Bonus roll, with BONUS_EN=1:
  - Player 0 captures 6, then captures 6 again.
  - Required: after the first roll turn stays 0. After the second, score0=12, turn=1 and no third bonus.
- Game end and tie, with ROUNDS=1:
  - Both players score 4.
  - Required: round_cnt=1, final_pulse for exactly 1 clk, game_over=1, winner=2'b11.
  - Then pulse roll_req[0]. Required: scores 0, game_over=0, turn=0.
- Saturation, with SCORE_W=3 and FACES=6:
  - Player scores 6 then 5. Required: score=7, no wrap.
- Async reset mid-ROLLING, with PLAYERS=4:
  - Drop rst between clk edges. Required: outputs are 0 immediately, without waiting for a clk edge.
  - After release, the first accepted request is from player 0.
